pulse_trig: RTL and testbench

Pulse staging, timing and trigger stage directly downstream of the core controller. Owns the quantum clock counter (qclk), holds pulse parameters written by the controller, and compares qclk against the commanded trigger time. On a hit it raises `cstrobe_out`, which feeds the controller's `cstrobe_in`, and launches the parameter set to the signal generator.

---
 rtl/pulse_trig.sv | 175 +++++++++++++++++
 tb/tb_pulse_trig.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_trig.sv
// pulse_trig: qclk counter, pulse parameter staging and trigger compare.
// Fires cstrobe_out when qclk reaches (or has passed) the commanded time and
// launches the staged pulse parameters to the signal generator.
//
// state | meaning
// IDLE  | waiting for an arm request; compares against cmd_time directly
// ARMED | trigger time latched, waiting for qclk to reach it
// DONE  | fired; waiting for c_strobe_enable to drop before re-arming
module pulse_trig #(
  parameter int QCLK_WIDTH  = 32,
  parameter int PHASE_WIDTH = 17,
  parameter int FREQ_WIDTH  = 9,
  parameter int AMP_WIDTH   = 16,
  parameter int ENV_WIDTH   = 24,
  parameter int CFG_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   qclk_load_en,
  input  logic [QCLK_WIDTH-1:0]  qclk_in,
  output logic [QCLK_WIDTH-1:0]  qclk_out,
  input  logic                   write_pulse_en,
  input  logic                   phase_we,
  input  logic                   freq_we,
  input  logic                   amp_we,
  input  logic                   env_we,
  input  logic                   cfg_we,
  input  logic [PHASE_WIDTH-1:0] phase_in,
  input  logic [FREQ_WIDTH-1:0]  freq_in,
  input  logic [AMP_WIDTH-1:0]   amp_in,
  input  logic [ENV_WIDTH-1:0]   env_in,
  input  logic [CFG_WIDTH-1:0]   cfg_in,
  input  logic [QCLK_WIDTH-1:0]  cmd_time,
  input  logic                   c_strobe_enable,
  output logic                   cstrobe_out,
  output logic [PHASE_WIDTH-1:0] pulse_phase,
  output logic [FREQ_WIDTH-1:0]  pulse_freq,
  output logic [AMP_WIDTH-1:0]   pulse_amp,
  output logic [ENV_WIDTH-1:0]   pulse_env,
  output logic [CFG_WIDTH-1:0]   pulse_cfg,
  output logic                   pulse_valid,
  output logic                   late_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DONE = 2'd2} state_t;

  localparam logic [QCLK_WIDTH-1:0] QCLK_ONE = QCLK_WIDTH'(1);

  state_t state, state_nxt;

  logic [QCLK_WIDTH-1:0]  qclk, t_lat, t_cur, diff;
  logic                   hit, late, fire, latch_t;

  logic [PHASE_WIDTH-1:0] st_phase, eff_phase;
  logic [FREQ_WIDTH-1:0]  st_freq, eff_freq;
  logic [AMP_WIDTH-1:0]   st_amp, eff_amp;
  logic [ENV_WIDTH-1:0]   st_env, eff_env;
  logic [CFG_WIDTH-1:0]   st_cfg, eff_cfg;

  // Same-cycle write bypass: the controller writes and arms together.
  assign eff_phase = (write_pulse_en && phase_we) ? phase_in : st_phase;
  assign eff_freq  = (write_pulse_en && freq_we)  ? freq_in  : st_freq;
  assign eff_amp   = (write_pulse_en && amp_we)   ? amp_in   : st_amp;
  assign eff_env   = (write_pulse_en && env_we)   ? env_in   : st_env;
  assign eff_cfg   = (write_pulse_en && cfg_we)   ? cfg_in   : st_cfg;

  // Modular difference; MSB clear and nonzero means qclk is past the target.
  assign t_cur = (state == ARMED) ? t_lat : cmd_time;
  assign diff  = qclk - t_cur;
  assign hit   = (diff == '0);
  assign late  = (diff != '0) && !diff[QCLK_WIDTH-1];

  assign qclk_out    = qclk;
  assign cstrobe_out = fire;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (c_strobe_enable) state_nxt = (hit || late) ? DONE : ARMED;
      end
      ARMED: begin
        if (!c_strobe_enable)  state_nxt = IDLE;
        else if (hit || late)  state_nxt = DONE;
      end
      DONE: begin
        if (!c_strobe_enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: fire strobe and trigger-time latch, both masked by reset.
  always_comb begin
    fire    = 1'b0;
    latch_t = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (c_strobe_enable) begin
            fire    = hit || late;
            latch_t = !(hit || late);
          end
        end
        ARMED: fire = c_strobe_enable && (hit || late);
        default: ;
      endcase
    end
  end

  // qclk counter: free-running with load from the controller's ALU.
  always_ff @(posedge clk) begin
    if (reset)             qclk <= '0;
    else if (qclk_load_en) qclk <= qclk_in;
    else                   qclk <= qclk + QCLK_ONE;
  end

  // Trigger time captured on the transition into ARMED.
  always_ff @(posedge clk) begin
    if (reset)        t_lat <= '0;
    else if (latch_t) t_lat <= cmd_time;
  end

  // Staging registers, written per field under write_pulse_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_phase <= '0;
      st_freq  <= '0;
      st_amp   <= '0;
      st_env   <= '0;
      st_cfg   <= '0;
    end else begin
      st_phase <= eff_phase;
      st_freq  <= eff_freq;
      st_amp   <= eff_amp;
      st_env   <= eff_env;
      st_cfg   <= eff_cfg;
    end
  end

  // Launch registers: capture effective fields on fire, one-cycle valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_phase <= '0;
      pulse_freq  <= '0;
      pulse_amp   <= '0;
      pulse_env   <= '0;
      pulse_cfg   <= '0;
      pulse_valid <= 1'b0;
    end else begin
      pulse_valid <= fire;
      if (fire) begin
        pulse_phase <= eff_phase;
        pulse_freq  <= eff_freq;
        pulse_amp   <= eff_amp;
        pulse_env   <= eff_env;
        pulse_cfg   <= eff_cfg;
      end
    end
  end

  // Sticky late flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)             late_err <= 1'b0;
    else if (fire && late) late_err <= 1'b1;
  end

endmodule

// File: tb/tb_pulse_trig.sv
// Testbench for pulse_trig: directed scenarios plus a randomized run checked
// against an arithmetic model of when a trigger must fire.
module tb_pulse_trig;

  logic        clk = 1'b0;
  logic        reset;
  logic        qclk_load_en;
  logic [31:0] qclk_in;
  logic [31:0] qclk_out;
  logic        write_pulse_en;
  logic        phase_we, freq_we, amp_we, env_we, cfg_we;
  logic [16:0] phase_in;
  logic [8:0]  freq_in;
  logic [15:0] amp_in;
  logic [23:0] env_in;
  logic [3:0]  cfg_in;
  logic [31:0] cmd_time;
  logic        c_strobe_enable;
  logic        cstrobe_out;
  logic [16:0] pulse_phase;
  logic [8:0]  pulse_freq;
  logic [15:0] pulse_amp;
  logic [23:0] pulse_env;
  logic [3:0]  pulse_cfg;
  logic        pulse_valid;
  logic        late_err;

  int tests = 0;
  int fails = 0;

  pulse_trig dut (
    .clk(clk), .reset(reset),
    .qclk_load_en(qclk_load_en), .qclk_in(qclk_in), .qclk_out(qclk_out),
    .write_pulse_en(write_pulse_en),
    .phase_we(phase_we), .freq_we(freq_we), .amp_we(amp_we), .env_we(env_we), .cfg_we(cfg_we),
    .phase_in(phase_in), .freq_in(freq_in), .amp_in(amp_in), .env_in(env_in), .cfg_in(cfg_in),
    .cmd_time(cmd_time), .c_strobe_enable(c_strobe_enable), .cstrobe_out(cstrobe_out),
    .pulse_phase(pulse_phase), .pulse_freq(pulse_freq), .pulse_amp(pulse_amp),
    .pulse_env(pulse_env), .pulse_cfg(pulse_cfg),
    .pulse_valid(pulse_valid), .late_err(late_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_writes();
    write_pulse_en = 0; phase_we = 0; freq_we = 0; amp_we = 0; env_we = 0; cfg_we = 0;
  endtask

  task automatic do_reset();
    reset = 1; c_strobe_enable = 0; qclk_load_en = 0; clear_writes();
    tick();
    reset = 0;
  endtask

  task automatic set_qclk(input logic [31:0] v);
    qclk_load_en = 1; qclk_in = v;
    tick();
    qclk_load_en = 0;
  endtask

  // Holds the arm request for ncyc cycles (dropping it from abort_at if >=0),
  // optionally loading qclk at load_at, and records what the DUT did.
  task automatic arm_run(input logic [31:0] t, input int ncyc, input int load_at,
                         input logic [31:0] load_val, input int abort_at,
                         output int fire_idx, output int n_fire, output logic [31:0] fire_q,
                         output int pv_idx, output int pv_cnt, output logic [31:0] q_after);
    fire_idx = -1; n_fire = 0; fire_q = '0; pv_idx = -1; pv_cnt = 0; q_after = '0;
    for (int i = 0; i < ncyc; i++) begin
      if (pulse_valid) begin
        pv_cnt++;
        if (pv_idx < 0) pv_idx = i;
      end
      if (fire_idx >= 0 && i == fire_idx + 1) q_after = qclk_out;
      cmd_time = t;
      c_strobe_enable = (abort_at < 0) || (i < abort_at);
      qclk_load_en = (i == load_at);
      qclk_in = load_val;
      #1;
      if (cstrobe_out) begin
        n_fire++;
        if (fire_idx < 0) begin fire_idx = i; fire_q = qclk_out; end
      end
      @(posedge clk); #1;
      if (i == 0) clear_writes();
    end
    qclk_load_en = 0; c_strobe_enable = 0;
    tick(); tick();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (qclk_out !== 32'd0) begin fails++; $display("FAIL reset_qclk got %0d want 0", qclk_out); end
    set_qclk(32'd5);
    cmd_time = 32'd100; c_strobe_enable = 1;
    tick(); tick();
    reset = 1; cmd_time = qclk_out; #1;
    tests++; if (cstrobe_out !== 1'b0) begin fails++; $display("FAIL reset_armed_strobe got %b want 0", cstrobe_out); end
    tick();
    reset = 0;
    tests++; if (qclk_out !== 32'd0) begin fails++; $display("FAIL reset_armed_qclk got %0d want 0", qclk_out); end
    tests++; if ({pulse_valid, late_err} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {pulse_valid, late_err}); end
    tests++; if ({pulse_phase, pulse_freq, pulse_amp, pulse_env, pulse_cfg} !== '0) begin fails++; $display("FAIL reset_pulse_regs got nonzero want 0"); end
    cmd_time = qclk_out; #1;
    tests++; if (cstrobe_out !== 1'b1) begin fails++; $display("FAIL reset_returns_idle strobe got %b want 1", cstrobe_out); end
    c_strobe_enable = 0; tick(); tick();
    reset = 1; c_strobe_enable = 1; cmd_time = qclk_out; #1;
    tests++; if (cstrobe_out !== 1'b0) begin fails++; $display("FAIL reset_cycle_strobe got %b want 0", cstrobe_out); end
    tick();
    reset = 0; c_strobe_enable = 0; tick();
  endtask

  task automatic test_basic();
    int fi, nf, pi, pc; logic [31:0] fq, qa;
    do_reset();
    set_qclk(32'd10);
    write_pulse_en = 1; amp_we = 1; amp_in = 16'h1234;
    arm_run(32'd15, 10, -1, '0, -1, fi, nf, fq, pi, pc, qa);
    tests++; if (fi !== 5 || fq !== 32'd15) begin fails++; $display("FAIL basic_fire got idx %0d qclk %0d want 5/15", fi, fq); end
    tests++; if (nf !== 1 || pc !== 1 || pi !== 6) begin fails++; $display("FAIL basic_valid got fires %0d valids %0d at %0d want 1/1/6", nf, pc, pi); end
    tests++; if (qa !== 32'd16) begin fails++; $display("FAIL basic_valid_qclk got %0d want 16", qa); end
    tests++; if (pulse_amp !== 16'h1234 || late_err !== 1'b0) begin fails++; $display("FAIL basic_amp got %h late %b want 1234/0", pulse_amp, late_err); end
  endtask

  task automatic test_bypass();
    int fi, nf, pi, pc; logic [31:0] fq, qa;
    set_qclk(32'd40);
    write_pulse_en = 1; phase_we = 1; phase_in = 17'h1ABCD;
    arm_run(32'd40, 4, -1, '0, -1, fi, nf, fq, pi, pc, qa);
    tests++; if (fi !== 0 || pi !== 1) begin fails++; $display("FAIL bypass_fire got idx %0d valid %0d want 0/1", fi, pi); end
    tests++; if (pulse_phase !== 17'h1ABCD || pulse_amp !== 16'h1234) begin fails++; $display("FAIL bypass_phase got %h amp %h want 1abcd/1234", pulse_phase, pulse_amp); end
  endtask

  task automatic test_late();
    int fi, nf, pi, pc; logic [31:0] fq, qa;
    set_qclk(32'd200);
    arm_run(32'd150, 4, -1, '0, -1, fi, nf, fq, pi, pc, qa);
    tests++; if (fi !== 0 || nf !== 1 || late_err !== 1'b1) begin fails++; $display("FAIL late_fire got idx %0d n %0d late %b want 0/1/1", fi, nf, late_err); end
    set_qclk(32'd300);
    arm_run(32'd305, 8, -1, '0, -1, fi, nf, fq, pi, pc, qa);
    tests++; if (fi !== 5 || late_err !== 1'b1) begin fails++; $display("FAIL late_sticky got idx %0d late %b want 5/1", fi, late_err); end
  endtask

  task automatic test_load_armed();
    int fi, nf, pi, pc; logic [31:0] fq, qa;
    do_reset(); set_qclk(32'd20);
    arm_run(32'd50, 6, 1, 32'd60, -1, fi, nf, fq, pi, pc, qa);
    tests++; if (fi !== 2 || fq !== 32'd60 || late_err !== 1'b1) begin fails++; $display("FAIL load_forward got idx %0d q %0d late %b want 2/60/1", fi, fq, late_err); end
    do_reset(); set_qclk(32'd20);
    arm_run(32'd50, 26, 1, 32'd30, -1, fi, nf, fq, pi, pc, qa);
    tests++; if (fi !== 22 || fq !== 32'd50 || late_err !== 1'b0) begin fails++; $display("FAIL load_backward got idx %0d q %0d late %b want 22/50/0", fi, fq, late_err); end
    set_qclk(32'd20);
    arm_run(32'd25, 9, 5, 32'd1000, -1, fi, nf, fq, pi, pc, qa);
    tests++; if (fi !== 5 || fq !== 32'd25 || qa !== 32'd1000) begin fails++; $display("FAIL load_on_hit got idx %0d q %0d after %0d want 5/25/1000", fi, fq, qa); end
  endtask

  task automatic test_wrap();
    int fi, nf, pi, pc; logic [31:0] fq, qa;
    do_reset(); set_qclk(32'hFFFF_FFFE);
    arm_run(32'd1, 6, -1, '0, -1, fi, nf, fq, pi, pc, qa);
    tests++; if (fi !== 3 || fq !== 32'd1 || late_err !== 1'b0) begin fails++; $display("FAIL wrap_fire got idx %0d q %0d late %b want 3/1/0", fi, fq, late_err); end
    set_qclk(32'hFFFF_FFFE);
    arm_run(32'd0, 5, -1, '0, -1, fi, nf, fq, pi, pc, qa);
    tests++; if (fi !== 2 || late_err !== 1'b0) begin fails++; $display("FAIL wrap_zero got idx %0d late %b want 2/0", fi, late_err); end
    set_qclk(32'hFFFF_FFFE);
    arm_run(32'd1, 6, -1, '0, 2, fi, nf, fq, pi, pc, qa);
    tests++; if (nf !== 0 || pc !== 0) begin fails++; $display("FAIL wrap_abort got fires %0d valids %0d want 0/0", nf, pc); end
  endtask

  // Random arms: fire time follows from the signed distance between qclk and
  // the target; fields follow the last qualified write.
  task automatic test_random();
    int fi, nf, pi, pc; logic [31:0] fq, qa;
    logic [31:0] q0, t, r;
    int delta, abort_at, exp_idx;
    bit exp_fire, m_late;
    logic [16:0] m_st_ph, m_pu_ph; logic [8:0] m_st_fr, m_pu_fr; logic [15:0] m_st_am, m_pu_am;
    logic [23:0] m_st_en, m_pu_en; logic [3:0] m_st_cf, m_pu_cf;
    do_reset();
    m_late = 0;
    m_st_ph = '0; m_st_fr = '0; m_st_am = '0; m_st_en = '0; m_st_cf = '0;
    m_pu_ph = '0; m_pu_fr = '0; m_pu_am = '0; m_pu_en = '0; m_pu_cf = '0;
    for (int n = 0; n < 40; n++) begin
      q0 = $urandom;
      delta = int'($urandom_range(60, 0)) - 30;
      t = q0 + 32'(delta);
      abort_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(35, 1)) : -1;
      set_qclk(q0);
      write_pulse_en = ($urandom_range(3, 0) != 0);
      r = $urandom;
      phase_we = r[0]; freq_we = r[1]; amp_we = r[2]; env_we = r[3]; cfg_we = r[4];
      r = $urandom; phase_in = r[16:0]; freq_in = r[25:17];
      r = $urandom; amp_in = r[15:0]; cfg_in = r[19:16];
      r = $urandom; env_in = r[23:0];
      if (write_pulse_en) begin
        if (phase_we) m_st_ph = phase_in;
        if (freq_we)  m_st_fr = freq_in;
        if (amp_we)   m_st_am = amp_in;
        if (env_we)   m_st_en = env_in;
        if (cfg_we)   m_st_cf = cfg_in;
      end
      exp_idx = (delta <= 0) ? 0 : delta;
      exp_fire = (abort_at < 0) || (abort_at > exp_idx);
      if (exp_fire) begin
        if (delta < 0) m_late = 1;
        m_pu_ph = m_st_ph; m_pu_fr = m_st_fr; m_pu_am = m_st_am; m_pu_en = m_st_en; m_pu_cf = m_st_cf;
      end
      arm_run(t, 40, -1, '0, abort_at, fi, nf, fq, pi, pc, qa);
      tests++;
      if (exp_fire && (fi !== exp_idx || nf !== 1 || pc !== 1 || pi !== exp_idx + 1)) begin
        fails++; $display("FAIL rand_fire[%0d] got idx %0d n %0d valid %0d/%0d want idx %0d", n, fi, nf, pc, pi, exp_idx);
      end else if (!exp_fire && (nf !== 0 || pc !== 0)) begin
        fails++; $display("FAIL rand_abort[%0d] got fires %0d valids %0d want 0/0", n, nf, pc);
      end
      tests++; if (late_err !== m_late) begin fails++; $display("FAIL rand_late[%0d] got %b want %b", n, late_err, m_late); end
      tests++;
      if ({pulse_phase, pulse_freq, pulse_amp, pulse_env, pulse_cfg} !== {m_pu_ph, m_pu_fr, m_pu_am, m_pu_en, m_pu_cf}) begin
        fails++; $display("FAIL rand_fields[%0d] got %h %h %h %h %h want %h %h %h %h %h", n,
          pulse_phase, pulse_freq, pulse_amp, pulse_env, pulse_cfg, m_pu_ph, m_pu_fr, m_pu_am, m_pu_en, m_pu_cf);
      end
    end
  endtask

  initial begin
    reset = 1; qclk_load_en = 0; qclk_in = '0; cmd_time = '0; c_strobe_enable = 0;
    phase_in = '0; freq_in = '0; amp_in = '0; env_in = '0; cfg_in = '0;
    clear_writes();
    #1;
    test_reset();
    test_basic();
    test_bypass();
    test_late();
    test_load_armed();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
